stopwatch_ctrl: RTL
===================

// Module: stopwatch_ctrl
// PURPOSE
//   Run/pause/lap controller for the 2-digit BCD millisecond counter.
//   Turns Start/Stop/Lap push-button levels into counter control: a 1-cycle
//   count-enable Tick every TICK_DIV clocks while running, and a Clear level.
//   Holds a lap snapshot and muxes it onto Display. Optionally halts at 99.
//   Sits between the board buttons and the counter/comparator datapath.
// PARAMETERS
//   TICK_DIV     100000  CLK cycles per count tick (1 ms at 100 MHz); >= 2
//   STOP_AT_MAX  1       1: stop in DONE at count 99; 0: keep ticking (counter wraps 99->00)
// PORTS
//   CLK       in   1  system clock, all logic on rising edge
//   RST       in   1  synchronous reset, active-high
//   Start     in   1  start/resume button level, already synchronised
//   Stop      in   1  pause/clear button level, already synchronised
//   Lap       in   1  lap hold/release button level, already synchronised
//   Count     in   8  live BCD count from the counter: [7:4] tens, [3:0] units
//   Tick      out  1  1-cycle count enable to the counter
//   Clear     out  1  counter clear, level
//   Display   out  8  BCD value to show: lap snapshot or live Count
//   Running   out  1  state == RUN
//   Done      out  1  state == DONE
//   Lap_Held  out  1  lap snapshot currently displayed
// BEHAVIOUR
//   Reset (RST=1 at edge): state IDLE, div=0, LapReg=8'h00, Lap_Held=0.
//     Button history regs are set to 1, so a button held through reset gives no edge.
//     Outputs in reset: Tick=0, Clear=1, Running=0, Done=0, Lap_Held=0, Display=Count.
//   Edge detect: xE = x & ~x_prev, where x_prev is registered each cycle. Only rising edges act.
//   FSM (next state registered; Stop edge beats Start edge in the same cycle):
//     IDLE : StartE -> RUN, with div <- 0.
//     RUN  : StopE -> PAUSE.
//            Max case (STOP_AT_MAX=1, Count==8'h99, div==TICK_DIV-1) -> DONE.
//     PAUSE: StopE -> IDLE. StartE -> RUN, with div kept (resumes mid-period).
//     DONE : StopE -> IDLE. StartE is ignored.
//   Prescaler div [ceil(log2 TICK_DIV)-1:0]:
//     Counts only in RUN. At TICK_DIV-1 it wraps to 0. Otherwise it holds.
//   Tick = (state==RUN) & (div==TICK_DIV-1) & ~(STOP_AT_MAX & Count==8'h99).
//     - Decoded from registered state only, so a StopE in the tick cycle does not mask it.
//     - First Tick comes TICK_DIV cycles after RUN is entered from IDLE.
//   Clear = (state==IDLE). The counter is held at 00 while idle.
//   Lap:
//     - LapE in RUN with Lap_Held=0: LapReg <- Count, Lap_Held <- 1.
//     - LapE with Lap_Held=1, any state: Lap_Held <- 0.
//     - Other LapE: ignored.
//     - Entering IDLE forces Lap_Held <- 0.
//   Display = Lap_Held ? LapReg : Count (combinational).
//   Count is trusted BCD. Values above 9 per digit are not checked here (comparator's job).
//   RST mid-operation overrides everything. IDLE in the next cycle, no Tick in that cycle.
// TESTING  (TICK_DIV=4 unless noted)
//   1 Hold Start=1 through RST, release RST -> stays IDLE, Clear=1, Tick=0;
//     Start 0->1 later -> Running=1 next cycle.
//   2 Start edge at cycle n -> Running=1 at n+1, Clear=0, Tick at n+4, n+8, n+12,
//     each 1 cycle wide.
//   3 Stop edge 2 cycles after a Tick -> PAUSE, no Tick; Start edge -> RUN, next Tick
//     after 1 more cycle. Stop, Stop -> IDLE, Clear=1.
//   4 Count=8'h99 in RUN, STOP_AT_MAX=1 -> no Tick, Done=1 at the would-be tick;
//     same with STOP_AT_MAX=0 -> Tick=1, Done=0.
//   5 Lap edge at Count=8'h37, Count moves to 8'h42 -> Display=8'h37, Lap_Held=1;
//     second Lap edge -> Display=8'h42.
//   6 Start and Stop edges in the same cycle in RUN -> PAUSE;
//     RST pulse in RUN -> IDLE, Lap_Held=0, Display=Count.

Source files
------------

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl
//   Run/pause/lap controller for a 2-digit BCD millisecond counter.
//   Converts Start/Stop/Lap button levels into a 1-cycle count-enable (Tick)
//   every TICK_DIV clocks while running, a Clear level while idle, and a lap
//   snapshot that can be muxed onto Display. With STOP_AT_MAX=1 the count
//   halts at 99 in the DONE state.
// Ports
//   CLK, RST          clock, synchronous active-high reset
//   Start/Stop/Lap    synchronised button levels (rising edge acts)
//   Count[7:0]        live BCD count ([7:4] tens, [3:0] units)
//   Tick              1-cycle count enable to the counter
//   Clear             counter clear level (state IDLE)
//   Display[7:0]      lap snapshot when held, else live Count
//   Running, Done     state == RUN / state == DONE
//   Lap_Held          lap snapshot currently displayed
module stopwatch_ctrl #(
  parameter int TICK_DIV    = 100000,
  parameter bit STOP_AT_MAX = 1'b1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       Start,
  input  logic       Stop,
  input  logic       Lap,
  input  logic [7:0] Count,
  output logic       Tick,
  output logic       Clear,
  output logic [7:0] Display,
  output logic       Running,
  output logic       Done,
  output logic       Lap_Held
);

  localparam int               DIV_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(TICK_DIV - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_DONE} state_t;

  state_t           r_state, w_next;
  logic [DIV_W-1:0] r_div;
  logic             r_start_q, r_stop_q, r_lap_q;
  logic [7:0]       r_lap_reg;
  logic             r_lap_held;

  logic w_start_e, w_stop_e, w_lap_e;
  logic w_div_end, w_at_max;

  assign w_start_e = Start & ~r_start_q;
  assign w_stop_e  = Stop  & ~r_stop_q;
  assign w_lap_e   = Lap   & ~r_lap_q;
  assign w_div_end = (r_div == DIV_MAX);
  assign w_at_max  = STOP_AT_MAX && (Count == 8'h99);

  // History regs reset to 1 so a button held through reset produces no edge.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_start_q <= 1'b1;
      r_stop_q  <= 1'b1;
      r_lap_q   <= 1'b1;
    end else begin
      r_start_q <= Start;
      r_stop_q  <= Stop;
      r_lap_q   <= Lap;
    end
  end

  // State register
  always_ff @(posedge CLK) begin
    if (RST) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next state: a Stop edge always wins over a Start edge in the same cycle.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_start_e && !w_stop_e) w_next = S_RUN;
      S_RUN: begin
        if (w_stop_e)                    w_next = S_PAUSE;
        else if (w_div_end && w_at_max)  w_next = S_DONE;
      end
      S_PAUSE: begin
        if (w_stop_e)                    w_next = S_IDLE;
        else if (w_start_e)              w_next = S_RUN;
      end
      S_DONE:  if (w_stop_e)             w_next = S_IDLE;
      default:                           w_next = S_IDLE;
    endcase
  end

  // Prescaler: restarts only on a fresh start from IDLE; a resume from
  // PAUSE keeps the partial period.
  always_ff @(posedge CLK) begin
    if (RST)
      r_div <= '0;
    else if (r_state == S_IDLE && w_next == S_RUN)
      r_div <= '0;
    else if (r_state == S_RUN)
      r_div <= w_div_end ? '0 : r_div + 1'b1;
  end

  // Lap snapshot: capture only while running, release in any state,
  // and always drop the hold when going idle.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_lap_reg  <= 8'h00;
      r_lap_held <= 1'b0;
    end else if (w_next == S_IDLE) begin
      r_lap_held <= 1'b0;
    end else if (w_lap_e) begin
      if (r_lap_held) begin
        r_lap_held <= 1'b0;
      end else if (r_state == S_RUN) begin
        r_lap_reg  <= Count;
        r_lap_held <= 1'b1;
      end
    end
  end

  // Outputs decode registered state only, so a Stop edge in the tick
  // cycle does not suppress that tick.
  always_comb begin
    Tick     = (r_state == S_RUN) && w_div_end && !w_at_max;
    Clear    = (r_state == S_IDLE);
    Running  = (r_state == S_RUN);
    Done     = (r_state == S_DONE);
    Lap_Held = r_lap_held;
    Display  = r_lap_held ? r_lap_reg : Count;
  end

endmodule
